// File: rtl/fetch_pkg.sv
// Shared constants, FSM state type and register-window decode for the fetch load/store front end.
package fetch_pkg;

  localparam logic [31:0] DEF_REG_BASE = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    BUS,
    DONE
  } state_t;

  // True when a lies inside [base, base + nregs)
  function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                     input int unsigned nregs);
    return (a >= base) && ((a - base) < 32'(nregs));
  endfunction

endpackage

// File: rtl/fetch_regfile.sv
// Per-thread register bank: NUM_THREADS x NUM_REGS x DATA_W, one write port, one registered read port.
module fetch_regfile
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned THREAD_W = $clog2(NUM_THREADS),
  localparam int unsigned REG_W = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [THREAD_W-1:0] thread,
  input  logic [REG_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [NUM_THREADS][NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < int'(NUM_THREADS); t++) begin
        for (int r = 0; r < int'(NUM_REGS); r++) begin
          mem[t][r] <= '0;
        end
      end
      rd_data <= '0;
    end else begin
      if (we) mem[thread][idx] <= wdata;
      if (re) rd_data <= mem[thread][idx];
    end
  end

endmodule

// File: rtl/fetch.sv
// CPU load/store front end: register-window hits served locally, everything else run on the W_* bus.
// FETCH_REGFILE_EN enables the local register file; without it every address goes over the bus.
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [31:0] REG_BASE = DEF_REG_BASE,
  localparam int unsigned THREAD_W = $clog2(NUM_THREADS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_enable,
  input  logic                write_mode,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [THREAD_W-1:0] thread,
  output logic [DATA_W-1:0]   data_o,
  output logic                ack,
  input  logic                W_CLK,
  input  logic                W_ACK,
  input  logic [DATA_W-1:0]   W_DATA_I,
  output logic [DATA_W-1:0]   W_DATA_O,
  output logic [ADDR_W-1:0]   W_ADDR,
  output logic                W_WRITE
);

  state_t state, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, bus_rdata, cap_data;
  logic wr_q, bus_own, bus_write;
  logic own_d, write_d, ack_d, load_c, done_c;
  logic gnt_c, wack_c, rf_hit_c;
  logic cap_tgl, cap_sync, cap_done, cap_pend_c, cap_flag_c;

  // Unknown strobe/acknowledge levels count as deasserted
  assign gnt_c  = (W_CLK === 1'b1);
  assign wack_c = (W_ACK === 1'b1);

  // Toggle handshake: flag is set while cap_tgl differs from the clk-domain copy
  assign cap_flag_c = cap_tgl ^ cap_done;
  assign cap_pend_c = cap_sync ^ cap_done;

`ifdef FETCH_REGFILE_EN
  localparam int unsigned REG_W = $clog2(NUM_REGS);

  logic              src_rf, rf_go_c;
  logic [REG_W-1:0]  rf_idx;
  logic [DATA_W-1:0] rf_rdata;

  assign rf_hit_c = in_window(32'(addr), REG_BASE, NUM_REGS);
  assign rf_go_c  = (state == IDLE) && f_enable && rf_hit_c;
  assign rf_idx   = REG_W'(32'(addr) - REG_BASE);

  fetch_regfile #(
    .DATA_W(DATA_W), .NUM_THREADS(NUM_THREADS), .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk(clk), .rst(rst),
    .we(rf_go_c && write_mode), .re(rf_go_c && !write_mode),
    .thread(thread), .idx(rf_idx), .wdata(data_i), .rd_data(rf_rdata)
  );

  // Remember whether the last completed read came from the register file or the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) src_rf <= 1'b0;
    else if (rf_go_c && !write_mode) src_rf <= 1'b1;
    else if (done_c && !wr_q) src_rf <= 1'b0;
  end

  assign data_o = src_rf ? rf_rdata : bus_rdata;
`else
  logic unused_c;
  assign unused_c = ^{thread, 32'(NUM_THREADS), 32'(NUM_REGS), REG_BASE};
  assign rf_hit_c = 1'b0;
  assign data_o   = bus_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    ack_d   = 1'b0;
    own_d   = bus_own;
    write_d = bus_write;
    load_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (f_enable) begin
          if (rf_hit_c) begin
            ack_d = 1'b1;
          end else begin
            load_c  = 1'b1;
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (gnt_c) begin
          state_d = BUS;
          own_d   = 1'b1;
          write_d = wr_q;
        end
      end
      BUS: begin
        // Completion is acknowledged only if the CPU is still asking
        if (cap_pend_c) begin
          state_d = DONE;
          own_d   = 1'b0;
          write_d = 1'b0;
          done_c  = 1'b1;
          ack_d   = f_enable;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack       <= 1'b0;
      bus_own   <= 1'b0;
      bus_write <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      bus_rdata <= '0;
      cap_sync  <= 1'b0;
      cap_done  <= 1'b0;
    end else begin
      ack       <= ack_d;
      bus_own   <= own_d;
      bus_write <= write_d;
      cap_sync  <= cap_tgl;
      if (load_c) begin
        addr_q <= addr;
        data_q <= data_i;
        wr_q   <= write_mode;
      end
      if (done_c) begin
        cap_done <= cap_sync;
        if (!wr_q) bus_rdata <= cap_data;
      end
    end
  end

  // Bus-slot domain: capture the slave acknowledge and its data once per transaction
  always_ff @(posedge W_CLK or posedge rst) begin
    if (rst) begin
      cap_tgl  <= 1'b0;
      cap_data <= '0;
    end else if (wack_c && (state == BUS) && !cap_flag_c) begin
      cap_tgl  <= ~cap_tgl;
      cap_data <= W_DATA_I;
    end
  end

  assign W_ADDR   = bus_own ? addr_q : {ADDR_W{1'bz}};
  assign W_DATA_O = (bus_own && bus_write) ? data_q : {DATA_W{1'bz}};
  assign W_WRITE  = bus_write;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: register-window vector table plus bus-transaction sequences.
module tb_fetch;

  logic        clk, rst, f_enable, write_mode;
  logic [31:0] addr, data_i, W_DATA_I;
  logic [1:0]  thread;
  logic        W_CLK, W_ACK;
  wire  [31:0] data_o, W_DATA_O, W_ADDR;
  wire         ack, W_WRITE;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        en;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  thr;
    logic        exp_ack;
    logic        chk_d;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic        exp_ack;
    logic        chk_d;
    logic [31:0] exp_d;
  } exp_t;

  exp_t sb[$];

  fetch dut (
    .clk(clk), .rst(rst), .f_enable(f_enable), .write_mode(write_mode),
    .addr(addr), .data_i(data_i), .thread(thread), .data_o(data_o), .ack(ack),
    .W_CLK(W_CLK), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I), .W_DATA_O(W_DATA_O),
    .W_ADDR(W_ADDR), .W_WRITE(W_WRITE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic addr_free();
    return (W_WRITE == 1'b0) && ($isunknown(W_ADDR) || W_ADDR == 32'h0);
  endfunction

  function automatic logic wdata_free();
    return $isunknown(W_DATA_O) || W_DATA_O == 32'h0;
  endfunction

  function automatic vec_t mk(input logic en, input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] thr, input logic exp_ack,
                              input logic chk_d, input logic [31:0] exp_d);
    vec_t v;
    v.en = en; v.we = we; v.a = a; v.d = d; v.thr = thr;
    v.exp_ack = exp_ack; v.chk_d = chk_d; v.exp_d = exp_d;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic exp_ack, input logic chk_d, input logic [31:0] exp_d);
    exp_t e;
    e.exp_ack = exp_ack; e.chk_d = chk_d; e.exp_d = exp_d;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_ack"}, 32'(ack), 32'(e.exp_ack));
      if (e.chk_d) chk({name, "_data"}, data_o, e.exp_d);
    end
  endtask

  // Slot strobe rising edge, optionally carrying an acknowledge and read data
  task automatic wclk_pulse(input logic a, input logic [31:0] d);
    W_CLK = 1'b0;
    #1;
    W_ACK = a;
    W_DATA_I = d;
    #1;
    W_CLK = 1'b1;
    #1;
    W_ACK = 1'b0;
    W_DATA_I = 32'h0;
  endtask

  task automatic wait_ack(input int max, output int n);
    n = 0;
    while (n < max) begin
      step();
      n++;
      if (ack === 1'b1) break;
    end
  endtask

  initial begin
    vec_t vecs[11];
    int   n;

    rst = 1'b1; f_enable = 1'b0; write_mode = 1'b0; addr = 32'h0; data_i = 32'h0;
    thread = 2'd0; W_CLK = 1'b0; W_ACK = 1'b0; W_DATA_I = 32'h0;
    step();
    step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_wwrite", 32'(W_WRITE), 32'd0);
    chk("rst_bus_free", 32'(addr_free()), 32'd1);
    rst = 1'b0;
    step();

`ifdef FETCH_REGFILE_EN
    vecs[0]  = mk(1'b1, 1'b1, 32'hFFFF_FFF0, 32'h1111_1111, 2'd0, 1'b1, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         2'd0, 1'b0, 1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b1, 32'hFFFF_FFF0, 32'hAAAA_0000, 2'd1, 1'b1, 1'b0, 32'h0);
    vecs[3]  = mk(1'b1, 1'b1, 32'hFFFF_FFF1, 32'h2222_2222, 2'd1, 1'b1, 1'b0, 32'h0);
    vecs[4]  = mk(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         2'd0, 1'b1, 1'b1, 32'h1111_1111);
    vecs[5]  = mk(1'b1, 1'b0, 32'hFFFF_FFF1, 32'h0,         2'd1, 1'b1, 1'b1, 32'h2222_2222);
    vecs[6]  = mk(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,         2'd1, 1'b1, 1'b1, 32'hAAAA_0000);
    vecs[7]  = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h3333_3333, 2'd3, 1'b1, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         2'd3, 1'b1, 1'b1, 32'h3333_3333);
    vecs[9]  = mk(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         2'd2, 1'b1, 1'b1, 32'h0);
    vecs[10] = mk(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0,         2'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      f_enable = vecs[i].en; write_mode = vecs[i].we; addr = vecs[i].a;
      data_i = vecs[i].d; thread = vecs[i].thr;
      push(vecs[i].exp_ack, vecs[i].chk_d, vecs[i].exp_d);
      step();
      sb_check($sformatf("rf_vec%0d", i));
      chk($sformatf("rf_vec%0d_bus_free", i), 32'(addr_free()), 32'd1);
    end
`else
    // Without the register file the window is just another bus address
    f_enable = 1'b1; write_mode = 1'b1; addr = 32'hFFFF_FFF4; data_i = 32'h77; W_CLK = 1'b1;
    push(1'b1, 1'b0, 32'h0);
    step();
    chk("win_wait_ack", 32'(ack), 32'd0);
    step();
    chk("win_waddr", W_ADDR, 32'hFFFF_FFF4);
    chk("win_wdata", W_DATA_O, 32'h77);
    wclk_pulse(1'b1, 32'h0);
    wait_ack(8, n);
    sb_check("win_done");
    f_enable = 1'b0;
    step();
    step();
`endif

    // Bus write held off by the strobe, then granted and acknowledged
    f_enable = 1'b1; write_mode = 1'b1; addr = 32'h1; data_i = 32'h11; thread = 2'd0; W_CLK = 1'b0;
    push(1'b1, 1'b0, 32'h0);
    step();
    chk("bw_wait1_ack", 32'(ack), 32'd0);
    chk("bw_wait1_free", 32'(addr_free()), 32'd1);
    step();
    chk("bw_wait2_ack", 32'(ack), 32'd0);
    chk("bw_wait2_free", 32'(addr_free()), 32'd1);
    W_CLK = 1'b1;
    step();
    chk("bw_waddr", W_ADDR, 32'h1);
    chk("bw_wdata", W_DATA_O, 32'h11);
    chk("bw_wwrite", 32'(W_WRITE), 32'd1);
    chk("bw_bus_ack", 32'(ack), 32'd0);
    wclk_pulse(1'b1, 32'h0);
    wait_ack(8, n);
    chk("bw_latency", 32'(n), 32'd2);
    sb_check("bw_done");
    chk("bw_release", 32'(addr_free()), 32'd1);
    f_enable = 1'b0;
    step();
    chk("bw_ack_pulse", 32'(ack), 32'd0);

    // Bus read; request inputs change after start and must not disturb the transaction
    f_enable = 1'b1; write_mode = 1'b0; addr = 32'h40; data_i = 32'h5555;
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    step();
    addr = 32'h999; data_i = 32'h0; write_mode = 1'b1;
    step();
    chk("br_waddr", W_ADDR, 32'h40);
    chk("br_wwrite", 32'(W_WRITE), 32'd0);
    chk("br_wdata_free", 32'(wdata_free()), 32'd1);
    wclk_pulse(1'b1, 32'hDEAD_BEEF);
    wait_ack(8, n);
    sb_check("br_done");
    f_enable = 1'b0;
    step();
    chk("br_data_hold", data_o, 32'hDEAD_BEEF);

    // Request withdrawn mid-transaction: bus still released, no ack
    f_enable = 1'b1; write_mode = 1'b1; addr = 32'h80; data_i = 32'h1234;
    step();
    step();
    chk("drop_waddr", W_ADDR, 32'h80);
    f_enable = 1'b0;
    wclk_pulse(1'b1, 32'h0);
    step();
    chk("drop_ack1", 32'(ack), 32'd0);
    step();
    chk("drop_ack2", 32'(ack), 32'd0);
    chk("drop_release", 32'(addr_free()), 32'd1);
    step();

    // Reset asserted while the bus is owned
    f_enable = 1'b1; write_mode = 1'b0; addr = 32'h40;
    step();
    step();
    chk("rstmid_waddr", W_ADDR, 32'h40);
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_free", 32'(addr_free()), 32'd1);
    chk("rstmid_ack", 32'(ack), 32'd0);
    f_enable = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("rstmid_idle_free", 32'(addr_free()), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
